// File: rtl/result_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter for calculator results.
// One shift per clock; sign/overflow/error flags travel with the presented digits.
module result_bcd_converter #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  input  logic                  negative,
  input  logic                  overflow,
  input  logic                  error,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  sign,
  output logic                  ovf_flag,
  output logic                  err_flag,
  output logic                  busy,
  output logic                  done
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   bin_reg;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_adj;
  logic [ACC_W-1:0]   acc_next;
  logic [CNT_W-1:0]   cnt;
  logic               neg_lat;
  logic               ovf_lat;
  logic               last_shift;

  assign last_shift = (cnt == CNT_W'(WIDTH - 1));

  // Add-3 correction on every digit, then shift in the next binary MSB.
  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
    acc_next = (acc_adj << 1) | {{(ACC_W-1){1'b0}}, bin_reg[WIDTH-1]};
  end

  // NOTE: every state register uses <= so all flops sample the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: each output gets a default first so no path through the case infers a latch.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE:  if (start) state_next = error ? DONE : SHIFT;
      SHIFT: begin
        busy = 1'b1;
        if (last_shift) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the accumulator and counter are reset too, so an aborted conversion leaves no residue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_reg  <= '0;
      acc      <= '0;
      cnt      <= '0;
      neg_lat  <= 1'b0;
      ovf_lat  <= 1'b0;
      bcd      <= '0;
      sign     <= 1'b0;
      ovf_flag <= 1'b0;
      err_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          bin_reg <= bin;
          neg_lat <= negative;
          ovf_lat <= overflow;
          acc     <= '0;
          cnt     <= '0;
          // Error results skip conversion and present blank digits next cycle.
          if (error) begin
            bcd      <= '0;
            sign     <= negative;
            ovf_flag <= overflow;
            err_flag <= 1'b1;
          end
        end
        SHIFT: begin
          acc     <= acc_next;
          bin_reg <= bin_reg << 1;
          cnt     <= cnt + 1'b1;
          if (last_shift) begin
            bcd      <= acc_next;
            sign     <= neg_lat;
            ovf_flag <= ovf_lat;
            err_flag <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_result_bcd_converter.sv
// Directed self-checking bench for result_bcd_converter (WIDTH=32, DIGITS=10).
module tb_result_bcd_converter;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] bin;
  logic        negative;
  logic        overflow;
  logic        error;
  logic [39:0] bcd;
  logic        sign;
  logic        ovf_flag;
  logic        err_flag;
  logic        busy;
  logic        done;

  int asserts;
  int failures;

  result_bcd_converter #(.WIDTH(32), .DIGITS(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bin      (bin),
    .negative (negative),
    .overflow (overflow),
    .error    (error),
    .bcd      (bcd),
    .sign     (sign),
    .ovf_flag (ovf_flag),
    .err_flag (err_flag),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a one-cycle start request; returns just after the start edge.
  task automatic start_conv(input logic [31:0] b, input logic n, input logic o, input logic e);
    @(negedge clk);
    bin      = b;
    negative = n;
    overflow = o;
    error    = e;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
  endtask

  // Counts negedges until done (lat=0 means it never came) and busy cycles seen.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    asserts++;
    if ({bcd, sign, ovf_flag, err_flag, busy, done} !== 45'd0) begin
      failures++;
      $display("FAIL reset_outputs: got bcd=%h s=%b o=%b e=%b busy=%b done=%b expected all 0",
               bcd, sign, ovf_flag, err_flag, busy, done);
    end
  endtask

  task automatic test_zero;
    int lat, bc;
    start_conv(32'd0, 1'b0, 1'b0, 1'b0);
    wait_done(lat, bc);
    asserts++;
    if (lat !== 33 || bc !== 32) begin
      failures++;
      $display("FAIL zero_latency: got lat=%0d busy=%0d expected lat=33 busy=32", lat, bc);
    end
    asserts++;
    if ({bcd, sign, ovf_flag, err_flag} !== 43'd0) begin
      failures++;
      $display("FAIL zero_result: got bcd=%h flags=%b%b%b expected 0", bcd, sign, ovf_flag, err_flag);
    end
    @(negedge clk);
    asserts++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL zero_done_pulse: got done=%b busy=%b expected 0 0", done, busy);
    end
  endtask

  task automatic test_negative;
    int lat, bc;
    start_conv(32'd12345, 1'b1, 1'b0, 1'b0);
    wait_done(lat, bc);
    asserts++;
    if (lat !== 33) begin
      failures++;
      $display("FAIL neg_latency: got %0d expected 33", lat);
    end
    asserts++;
    if (bcd !== 40'h0000012345 || sign !== 1'b1 || ovf_flag !== 1'b0 || err_flag !== 1'b0) begin
      failures++;
      $display("FAIL neg_result: got bcd=%h s=%b o=%b e=%b expected 0000012345 1 0 0",
               bcd, sign, ovf_flag, err_flag);
    end
    bin = 32'd777;
    negative = 1'b0;
    repeat (5) @(negedge clk);
    asserts++;
    if (bcd !== 40'h0000012345 || sign !== 1'b1) begin
      failures++;
      $display("FAIL neg_hold: got bcd=%h s=%b expected 0000012345 1", bcd, sign);
    end
  endtask

  task automatic test_max_overflow;
    int lat, bc;
    start_conv(32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);
    wait_done(lat, bc);
    asserts++;
    if (lat !== 33 || bcd !== 40'h4294967295 || ovf_flag !== 1'b1 || sign !== 1'b0 || err_flag !== 1'b0) begin
      failures++;
      $display("FAIL max_ovf: got lat=%0d bcd=%h s=%b o=%b e=%b expected 33 4294967295 0 1 0",
               lat, bcd, sign, ovf_flag, err_flag);
    end
  endtask

  task automatic test_error;
    int lat, bc;
    start_conv(32'd7, 1'b0, 1'b0, 1'b1);
    wait_done(lat, bc);
    asserts++;
    if (lat !== 1 || bc !== 0) begin
      failures++;
      $display("FAIL err_latency: got lat=%0d busy=%0d expected 1 0", lat, bc);
    end
    asserts++;
    if (bcd !== 40'd0 || err_flag !== 1'b1 || ovf_flag !== 1'b0) begin
      failures++;
      $display("FAIL err_result: got bcd=%h e=%b o=%b expected 0 1 0", bcd, err_flag, ovf_flag);
    end
    error = 1'b0;
  endtask

  task automatic test_ignore_start;
    int lat, bc;
    start_conv(32'd99, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bin = 32'd12345; negative = 1'b1; overflow = 1'b1; error = 1'b1; start = 1'b1;
    repeat (5) @(negedge clk);
    start = 1'b0; error = 1'b0;
    wait_done(lat, bc);
    asserts++;
    if (lat + 6 !== 33) begin
      failures++;
      $display("FAIL ignore_latency: got %0d expected 33", lat + 6);
    end
    asserts++;
    if (bcd !== 40'h0000000099 || sign !== 1'b0 || ovf_flag !== 1'b0 || err_flag !== 1'b0) begin
      failures++;
      $display("FAIL ignore_result: got bcd=%h s=%b o=%b e=%b expected 0000000099 0 0 0",
               bcd, sign, ovf_flag, err_flag);
    end
    negative = 1'b0; overflow = 1'b0;
  endtask

  task automatic test_reset_abort;
    int lat, bc;
    int seen_done;
    start_conv(32'd777, 1'b1, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    asserts++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL abort_busy_before: got %b expected 1", busy);
    end
    #2 rst = 1'b1;
    #1;
    asserts++;
    if ({bcd, sign, ovf_flag, err_flag, busy, done} !== 45'd0) begin
      failures++;
      $display("FAIL abort_outputs: got bcd=%h s=%b o=%b e=%b busy=%b done=%b expected all 0",
               bcd, sign, ovf_flag, err_flag, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    seen_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen_done++;
    end
    asserts++;
    if (seen_done !== 0) begin
      failures++;
      $display("FAIL abort_no_done: got %0d active cycles expected 0", seen_done);
    end
    start_conv(32'd500, 1'b0, 1'b0, 1'b0);
    wait_done(lat, bc);
    asserts++;
    if (lat !== 33 || bcd !== 40'h0000000500 || sign !== 1'b0 || ovf_flag !== 1'b0) begin
      failures++;
      $display("FAIL abort_restart: got lat=%0d bcd=%h s=%b o=%b expected 33 0000000500 0 0",
               lat, bcd, sign, ovf_flag);
    end
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    @(negedge clk);
    bin = 32'd42; start = 1'b1;
    @(posedge clk);
    wait_done(lat, bc);
    asserts++;
    if (lat !== 33 || bcd !== 40'h0000000042) begin
      failures++;
      $display("FAIL b2b_first: got lat=%0d bcd=%h expected 33 0000000042", lat, bcd);
    end
    bin = 32'd7;
    @(negedge clk);
    asserts++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle: got busy=%b done=%b expected 0 0", busy, done);
    end
    @(negedge clk);
    asserts++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_restart: got busy=%b expected 1", busy);
    end
    start = 1'b0;
    wait_done(lat, bc);
    asserts++;
    if (lat !== 32 || bcd !== 40'h0000000007) begin
      failures++;
      $display("FAIL b2b_second: got lat=%0d bcd=%h expected 32 0000000007", lat, bcd);
    end
  endtask

  initial begin
    asserts  = 0;
    failures = 0;
    rst      = 1'b1;
    start    = 1'b0;
    bin      = '0;
    negative = 1'b0;
    overflow = 1'b0;
    error    = 1'b0;
    #3;
    test_reset;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_zero;
    test_negative;
    test_max_overflow;
    test_error;
    test_ignore_start;
    test_reset_abort;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
